// File: rtl/sme_feeder.sv
// Purpose: buffers host string/pattern records in a FIFO and replays each job
//          (optional string record + one pattern record) to the string-matching
//          engine as a gap-free isstring/ispattern/chardata burst, then waits for
//          the matcher's valid and counts completed jobs.
// Latency: pattern last byte written at edge N -> first job byte on chardata after
//          edge N+1; one byte per cycle thereafter.
// Backpressure: in_ready = !fifo_full; a write while full is refused even if a pop
//          happens in the same cycle. Over-limit record bytes are accepted and dropped.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_data/in_kind/in_last : host byte stream (kind 0=string, 1=pattern)
//   chardata/isstring/ispattern               : registered burst towards the matcher
//   sme_valid                                 : matcher result valid
//   busy, jobs_done, err_trunc                : status

module sme_feeder #(
    parameter int DEPTH   = 64,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_kind,
    input  logic        in_last,
    output logic [7:0]  chardata,
    output logic        isstring,
    output logic        ispattern,
    input  logic        sme_valid,
    output logic        busy,
    output logic [15:0] jobs_done,
    output logic        err_trunc
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(STR_MAX + PAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // FIFO storage: {kind, last, data}
    logic [9:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fill;
    logic          fifo_full;
    logic          fifo_empty;
    logic [9:0]    head;
    logic [AW-1:0] prev_idx;

    // ingest tracking
    logic [LW-1:0] len;
    logic          kind_q;
    logic          first;
    logic          cur_kind;
    logic [LW-1:0] lim;
    logic          accept;
    logic          drop;
    logic          wr_en;
    logic          fix_last;
    logic          pat_inc;
    logic          pat_dec;
    logic [AW:0]   pat_cnt;

    // replay FSM
    state_t        state_q;
    state_t        state_d;
    logic          pop;
    logic          job_inc;
    logic          drv_last;

    assign fill       = wr_ptr - rd_ptr;
    assign fifo_full  = (fill == (AW+1)'(DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign in_ready   = !fifo_full;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign prev_idx   = wr_ptr[AW-1:0] - AW'(1);

    assign accept   = in_valid && in_ready;
    assign first    = (len == '0);
    // kind is taken from the bus only on a record's first byte
    assign cur_kind = first ? in_kind : kind_q;
    assign lim      = cur_kind ? LW'(PAT_MAX) : LW'(STR_MAX);
    // len saturates at the limit, so every further byte of the record is dropped
    assign drop     = (len >= lim);
    assign wr_en    = accept && !drop;
    assign fix_last = accept && drop && in_last;
    // a pattern record completes either by writing its last byte or by the
    // last-bit rewrite of a truncated record
    assign pat_inc  = accept && in_last && cur_kind;
    assign pat_dec  = pop && head[9] && head[8];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {cur_kind, in_last, in_data};
        end else if (fix_last) begin
            // The rewritten entry cannot have been popped yet: nothing of an
            // unfinished record leaves the FIFO until a later pattern last exists.
            mem[prev_idx][8] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len       <= '0;
            kind_q    <= 1'b0;
            pat_cnt   <= '0;
            err_trunc <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (accept) begin
                if (first) begin
                    kind_q <= in_kind;
                end
                if (in_last) begin
                    len <= '0;
                end else if (!drop) begin
                    len <= len + LW'(1);
                end
                if (drop) begin
                    err_trunc <= 1'b1;
                end
            end
            case ({pat_inc, pat_dec})
                2'b10:   pat_cnt <= pat_cnt + (AW+1)'(1);
                2'b01:   pat_cnt <= pat_cnt - (AW+1)'(1);
                default: pat_cnt <= pat_cnt;
            endcase
        end
    end

    // A job launches only once its pattern last is resident, so SEND never
    // finds the FIFO empty. drv_last marks that the byte currently on the
    // outputs closes the job; SEND then stops popping and moves on.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        job_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (pat_cnt != '0) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (drv_last) begin
                    state_d = GUARD;
                end else begin
                    pop = 1'b1;
                end
            end
            GUARD: begin
                // matcher still updating its state; its valid is not trusted here
                state_d = WAIT;
            end
            WAIT: begin
                if (sme_valid) begin
                    job_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            chardata  <= 8'd0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            drv_last  <= 1'b0;
            jobs_done <= 16'd0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                chardata  <= head[7:0];
                isstring  <= !head[9];
                ispattern <= head[9];
                drv_last  <= head[9] && head[8];
            end else begin
                chardata  <= 8'd0;
                isstring  <= 1'b0;
                ispattern <= 1'b0;
                drv_last  <= 1'b0;
            end
            if (job_inc) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sme_feeder.sv
// Purpose: directed self-checking bench for sme_feeder (jobs, truncation,
//          host stalls, full FIFO, mid-burst reset).
// Latency: expectations are hand-derived cycle positions relative to the
//          edge that writes a job's pattern last byte.
// Backpressure: host driver waits on in_ready with a bounded cycle budget.

module tb_sme_feeder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_kind;
    logic        in_last;
    logic [7:0]  chardata;
    logic        isstring;
    logic        ispattern;
    logic        sme_valid;
    logic        busy;
    logic [15:0] jobs_done;
    logic        err_trunc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cyc = 0;

    logic [7:0] q_dat [$];
    logic       q_kind [$];
    int         q_cyc [$];

    sme_feeder #(.DEPTH(64), .STR_MAX(32), .PAT_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_kind   (in_kind),
        .in_last   (in_last),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .busy      (busy),
        .jobs_done (jobs_done),
        .err_trunc (err_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // capture every byte handed to the matcher, with its cycle number
    always @(negedge clk) begin
        if (isstring || ispattern) begin
            q_dat.push_back(chardata);
            q_kind.push_back(ispattern);
            q_cyc.push_back(cyc);
        end
        if (isstring && ispattern)
            check("kind_exclusive", 1, 0);
        if (!reset && dut.pop && dut.fifo_empty)
            check("pop_while_empty", 1, 0);
    end

    task automatic clear_log();
        q_dat.delete();
        q_kind.delete();
        q_cyc.delete();
    endtask

    function automatic logic gapfree();
        for (int i = 0; i < q_cyc.size(); i++)
            if (q_cyc[i] != q_cyc[0] + i) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_kind(input logic k);
        int n = 0;
        for (int i = 0; i < q_kind.size(); i++)
            if (q_kind[i] == k) n++;
        return n;
    endfunction

    // drive one byte; returns #1 after the accepting edge with wr_cyc set
    task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_kind  = k;
        in_last  = l;
        @(posedge clk);
        #1;
        wr_cyc   = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // one-cycle matcher valid; jobs_done must reach exp the cycle after
    task automatic pulse_valid(input string tag, input int exp);
        sme_valid = 1'b1;
        @(posedge clk);
        #1;
        sme_valid = 1'b0;
        check(tag, jobs_done, exp);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_kind   = 1'b0;
        in_last   = 1'b0;
        sme_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_chardata", chardata, 0);
        check("rst_isstring", isstring, 0);
        check("rst_ispattern", ispattern, 0);
        check("rst_busy", busy, 0);
        check("rst_jobs", jobs_done, 0);
        check("rst_err", err_trunc, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // job 1: string "abc", pattern "b"
        clear_log();
        send_byte("a", 0, 0);
        send_byte("b", 0, 0);
        send_byte("c", 0, 1);
        send_byte("b", 1, 1);
        repeat (5) @(posedge clk);
        #1;
        check("j1_guard_busy", busy, 1);
        check("j1_guard_quiet", {isstring, ispattern}, 2'b00);
        check("j1_count", q_dat.size(), 4);
        check("j1_data", {q_dat[0], q_dat[1], q_dat[2], q_dat[3]}, "abcb");
        check("j1_kind", {q_kind[0], q_kind[1], q_kind[2], q_kind[3]}, 4'b0001);
        check("j1_gapfree", gapfree(), 1);
        check("j1_latency", q_cyc[0], wr_cyc + 1);
        repeat (4) @(posedge clk);
        #1;
        check("j1_jobs_before", jobs_done, 0);
        pulse_valid("j1_jobs", 1);

        // job 2: pattern-only "x*"
        clear_log();
        send_byte("x", 1, 0);
        send_byte("*", 1, 1);
        repeat (8) @(posedge clk);
        #1;
        check("j2_count", q_dat.size(), 2);
        check("j2_no_string", count_kind(0), 0);
        check("j2_data", {q_dat[0], q_dat[1]}, "x*");
        check("j2_gapfree", gapfree(), 1);
        check("j2_err_clear", err_trunc, 0);
        pulse_valid("j2_jobs", 2);

        // job 3: 40-byte string, 10-byte pattern -> 32 + 8 driven
        clear_log();
        for (int i = 0; i < 40; i++) send_byte(8'(i), 0, i == 39);
        for (int j = 0; j < 10; j++) send_byte(8'h80 + 8'(j), 1, j == 9);
        repeat (50) @(posedge clk);
        #1;
        check("j3_err", err_trunc, 1);
        check("j3_count", q_dat.size(), 40);
        check("j3_str_bytes", count_kind(0), 32);
        check("j3_pat_bytes", count_kind(1), 8);
        check("j3_last_str", q_dat[31], 8'd31);
        check("j3_first_pat", q_dat[32], 8'h80);
        check("j3_end", {q_kind[39], q_dat[39]}, 9'h187);
        check("j3_gapfree", gapfree(), 1);
        pulse_valid("j3_jobs", 3);

        // job 4: host stalls, one string byte every 4 cycles
        clear_log();
        send_byte("p", 0, 0);
        repeat (3) @(posedge clk);
        send_byte("q", 0, 0);
        repeat (3) @(posedge clk);
        send_byte("r", 0, 0);
        repeat (3) @(posedge clk);
        send_byte("s", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("j4_nothing_early", q_dat.size(), 0);
        send_byte("q", 1, 1);
        repeat (10) @(posedge clk);
        #1;
        check("j4_count", q_dat.size(), 5);
        check("j4_data", {q_dat[0], q_dat[1], q_dat[2], q_dat[3], q_dat[4]}, "pqrsq");
        check("j4_gapfree", gapfree(), 1);
        check("j4_latency", q_cyc[0], wr_cyc + 1);
        pulse_valid("j4_jobs", 4);

        // fill: job A parks the FSM in WAIT, then 64 entries are loaded
        send_byte("s", 0, 1);
        send_byte("t", 1, 1);
        repeat (10) @(posedge clk);
        clear_log();
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), (i % 32) >= 30, (i % 32) == 29 || (i % 32) == 31);
        end
        check("fill_ready_low", in_ready, 0);
        check("fill_held", q_dat.size(), 0);
        pulse_valid("fill_jobs_a", 5);
        repeat (40) @(posedge clk);
        #1;
        pulse_valid("fill_jobs_b", 6);
        repeat (40) @(posedge clk);
        #1;
        pulse_valid("fill_jobs_c", 7);
        check("fill_count", q_dat.size(), 64);
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++)
                if (q_dat[i] != 8'(i) || q_kind[i] != ((i % 32) >= 30)) bad++;
            check("fill_data", bad, 0);
        end
        check("fill_ready_back", in_ready, 1);

        // reset during the 2nd string byte
        clear_log();
        send_byte("d", 0, 0);
        send_byte("e", 0, 1);
        send_byte("f", 1, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst2_mid_burst", {isstring, chardata}, {1'b1, 8'h65});
        reset = 1'b1;
        #1;
        check("rst2_chardata", chardata, 0);
        check("rst2_kind", {isstring, ispattern}, 2'b00);
        check("rst2_busy", busy, 0);
        check("rst2_jobs", jobs_done, 0);
        check("rst2_err", err_trunc, 0);
        check("rst2_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send_byte("g", 0, 1);
        send_byte("h", 1, 1);
        repeat (8) @(posedge clk);
        #1;
        check("rst2_job_count", q_dat.size(), 2);
        check("rst2_job_data", {q_dat[0], q_dat[1]}, "gh");
        pulse_valid("rst2_job_jobs", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Upstream loader for the string-matching engine. It accepts string and pattern records from a host byte stream with a ready/valid handshake and buffers them in a FIFO. Each job is replayed to the matcher as a gap-free `isstring`/`ispattern`/`chardata` burst. Before launching the next job it waits for the matcher's `valid`, and it counts completed jobs.

## Interface
- `DEPTH`, 64: FIFO entries. Power of two, at least `STR_MAX+PAT_MAX`.
- `STR_MAX`, 32: maximum string bytes forwarded per record.
- `PAT_MAX`, 8: maximum pattern bytes forwarded per record.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: host byte valid.
- `in_ready` output 1: feeder can accept a byte. Equals `!fifo_full`.
- `in_data` input 8: host byte.
- `in_kind` input 1: record type, 0=string, 1=pattern. Sampled only on the first byte of a record.
- `in_last` input 1: final byte of the record.
- `chardata` output 8: byte to the matcher. Registered.
- `isstring` output 1: `chardata` is a string byte. Registered.
- `ispattern` output 1: `chardata` is a pattern byte. Registered.
- `sme_valid` input 1: matcher result valid.
- `busy` output 1: a job is being sent or awaiting its result.
- `jobs_done` output 16: completed jobs. Wraps at 16'hFFFF→0.
- `err_trunc` output 1: sticky. Set when any record is truncated.

## Operation
- FIFO entry format is {kind, last, data}, 10 bits wide. A write happens on `in_valid && in_ready`.
- Ingest length counter `len` resets to 0 after each `last`. The record kind is latched on its first byte.
  - Bytes beyond the limit for the latched kind (`STR_MAX` or `PAT_MAX`) are accepted but not written, and `err_trunc` is set.
  - If such a dropped byte carries `in_last`, the entry at `wr_ptr-1` has its last bit set instead.
  - A record whose first byte is already over the limit cannot occur, because the limits are at least 1.
- `pat_cnt` holds the number of complete pattern records in the FIFO.
  - It increments when a pattern last-bit is written, including the rewrite case above.
  - It decrements when a pattern last-entry is popped.
  - Simultaneous increment and decrement leaves it unchanged.
- Job = optional string record followed by one pattern record. A pattern-only job reuses the matcher's previous string.
- Launch rule: a job starts only when `pat_cnt≥1`. FIFO order then guarantees the whole job is resident, so the burst is gap-free.
- FSM states:
  - IDLE: if `pat_cnt≥1`, pop the head, drive it, and go to SEND.
  - SEND: pop one entry per cycle.
    - Drive `isstring=!kind` or `ispattern=kind` together with `chardata=data`.
    - Popping a pattern entry with last set goes to GUARD.
  - GUARD: one cycle with `isstring=ispattern=0`, `sme_valid` ignored. Go to WAIT.
  - WAIT: hold outputs low. When `sme_valid=1`, increment `jobs_done` and go to IDLE.
- IDLE launches in the same cycle it observes `pat_cnt≥1`. The fastest spacing between jobs is therefore one idle cycle after a `valid` is seen.
- A string record directly followed by a pattern record is driven as one contiguous burst with no idle cycle between them.
- If the FIFO holds two string records before a pattern, both are sent back-to-back. The matcher concatenation is the host's responsibility; the feeder does not check for it.
- `busy` is 1 in SEND, GUARD and WAIT.

## Timing
- Reset values: `chardata=0`, `isstring=0`, `ispattern=0`, `busy=0`, `jobs_done=0`, `err_trunc=0`, `in_ready=1`. FIFO pointers, `pat_cnt` and `len` are cleared and the FSM returns to IDLE.
- Reset mid-burst drops the outputs to 0 immediately (asynchronous) and discards all FIFO contents.
- Latency: the pattern last byte written at edge N makes `pat_cnt≥1` after N. The first byte appears on `chardata` after edge N+1.
- Full FIFO: `in_ready=0`. Because a pop is registered, a write while full and popping is still refused.
- Empty FIFO in SEND cannot occur by construction. Verification asserts on it.
- A `sme_valid` already high when WAIT is entered is accepted; the GUARD cycle covers the matcher's state-update latency.

## Test plan
- Ingest string "abc" then pattern "b", then raise `sme_valid` 5 cycles after the burst.
  - Required: `isstring` high with a, b, c on consecutive cycles, then `ispattern` with b on the next cycle.
  - Then one GUARD cycle. `jobs_done` becomes 1 the cycle after `valid`.
- Send a pattern-only job "x*" after job 1.
  - Required: no `isstring` pulse; `ispattern` high for 2 cycles; `jobs_done=2`.
- Send a 40-byte string with a pattern of 10 bytes.
  - Required: exactly 32 string and 8 pattern bytes are driven.
  - `err_trunc=1`, and the pattern's last byte ends the burst.
- Host stalls mid-string, with string bytes arriving 1 per 4 cycles.
  - Required: nothing is driven until the pattern `last` is written, then the burst is gap-free.
- Fill the FIFO to 64 entries while the matcher never asserts `valid`.
  - Required: `in_ready=0` at 64 entries, and no byte is lost after `valid` resumes.
- Assert `reset` during the 2nd string byte.
  - Required: all outputs are 0 the same cycle, and a new job afterwards runs correctly with `jobs_done=1`.
